// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive deframer.
// Holds frame bit positions, parity mode encodings, the deframer FSM state
// type and the layout of one FIFO word ({frame_err, parity_err, data}).
package uart_rx_pkg;

    localparam int START_BIT = 0;
    localparam int DATA_LSB  = 1;
    localparam int DATA_MSB  = 8;
    localparam int PAR_BIT   = 9;
    localparam int STOP_BIT  = 10;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_NONE = 2;

    localparam int FIFO_W = 10;

    typedef enum logic {
        StIdle,
        StCheck
    } state_e;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } fifo_word_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes plus status.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push, i_wdata write request and word
//   i_pop          read request (ignored when empty)
//   o_rdata        word at head (undefined content when empty)
//   o_full/o_empty occupancy flags
//   o_count        number of words held, 0..DEPTH
// A push while full succeeds only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // Full is fine when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: takes the 11-bit frame from the shifter on the rising
// edge of its completion flag, checks start/stop and parity, and queues the
// byte with its status in a FIFO read by the host via valid/ready.
// Ports:
//   baud_clk, rst         clock, synchronous active-high reset
//   recieved_flag         frame-complete strobe from the shifter
//   data_parll[10:0]      {stop, parity, data[7:0] LSB-first, start}
//   rx_data, rx_parity_err, rx_frame_err  head entry, zero when empty
//   rx_valid, rx_ready    host handshake
//   overrun, clr_overrun  sticky drop indicator and its clear
//   fifo_count            entries held
module uart_rx_deframe
    import uart_rx_pkg::*;
#(
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 3
) (
    input  logic             baud_clk,
    input  logic             rst,
    input  logic             recieved_flag,
    input  logic [10:0]      data_parll,
    output logic [7:0]       rx_data,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] fifo_count
);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_flag_q;
    logic [10:0] r_frame_q;
    logic        r_overrun;

    logic        w_new_frame;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;
    logic        w_par_xor;
    logic        w_parity_err;
    logic        w_frame_err;
    fifo_word_t  w_wword;
    logic [FIFO_W-1:0] w_rword_raw;
    fifo_word_t  w_rword;

    assign w_new_frame = recieved_flag && !r_flag_q;

    always_comb begin
        w_state_d = r_state;
        w_push    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_new_frame) begin
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                w_push    = 1'b1;
                w_state_d = w_new_frame ? StCheck : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_par_xor   = ^r_frame_q[PAR_BIT:DATA_LSB];
    assign w_frame_err = r_frame_q[START_BIT] | ~r_frame_q[STOP_BIT];

    always_comb begin
        w_parity_err = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) begin
            w_parity_err = w_par_xor;
        end else if (PARITY_MODE == PARITY_ODD) begin
            w_parity_err = ~w_par_xor;
        end
    end

    assign w_wword.frame_err  = w_frame_err;
    assign w_wword.parity_err = w_parity_err;
    assign w_wword.data       = r_frame_q[DATA_MSB:DATA_LSB];

    assign rx_valid = !w_empty;
    assign w_pop    = rx_valid && rx_ready;
    assign w_drop   = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (baud_clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata (w_wword),
        .i_pop   (w_pop),
        .o_rdata (w_rword_raw),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_rword       = w_empty ? '0 : fifo_word_t'(w_rword_raw);
    assign rx_data       = w_rword.data;
    assign rx_parity_err = w_rword.parity_err;
    assign rx_frame_err  = w_rword.frame_err;
    assign overrun       = r_overrun;

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            // Flag history starts high so a strobe already up at release is ignored.
            r_flag_q  <= 1'b1;
            r_frame_q <= '0;
            r_state   <= StIdle;
            r_overrun <= 1'b0;
        end else begin
            r_flag_q <= recieved_flag;
            if (w_new_frame) begin
                r_frame_q <= data_parll;
            end
            r_state <= w_state_d;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframe.sv
module tb_uart_rx_deframe;

    logic        baud_clk = 1'b0;
    logic        rst;
    logic        recieved_flag;
    logic [10:0] data_parll;
    logic        rx_ready;
    logic        clr_overrun;

    // Three instances share stimulus: even, odd and no parity.
    logic [7:0] e_data, o_data, n_data;
    logic       e_pe, o_pe, n_pe;
    logic       e_fe, o_fe, n_fe;
    logic       e_valid, o_valid, n_valid;
    logic       e_ovr, o_ovr, n_ovr;
    logic [2:0] e_cnt, o_cnt, n_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 baud_clk = ~baud_clk;

    uart_rx_deframe #(.PARITY_MODE(0), .FIFO_DEPTH(4), .CNT_W(3)) dut_e (
        .baud_clk(baud_clk), .rst(rst), .recieved_flag(recieved_flag),
        .data_parll(data_parll), .rx_data(e_data), .rx_parity_err(e_pe),
        .rx_frame_err(e_fe), .rx_valid(e_valid), .rx_ready(rx_ready),
        .overrun(e_ovr), .clr_overrun(clr_overrun), .fifo_count(e_cnt)
    );

    uart_rx_deframe #(.PARITY_MODE(1), .FIFO_DEPTH(4), .CNT_W(3)) dut_o (
        .baud_clk(baud_clk), .rst(rst), .recieved_flag(recieved_flag),
        .data_parll(data_parll), .rx_data(o_data), .rx_parity_err(o_pe),
        .rx_frame_err(o_fe), .rx_valid(o_valid), .rx_ready(rx_ready),
        .overrun(o_ovr), .clr_overrun(clr_overrun), .fifo_count(o_cnt)
    );

    uart_rx_deframe #(.PARITY_MODE(2), .FIFO_DEPTH(4), .CNT_W(3)) dut_n (
        .baud_clk(baud_clk), .rst(rst), .recieved_flag(recieved_flag),
        .data_parll(data_parll), .rx_data(n_data), .rx_parity_err(n_pe),
        .rx_frame_err(n_fe), .rx_valid(n_valid), .rx_ready(rx_ready),
        .overrun(n_ovr), .clr_overrun(clr_overrun), .fifo_count(n_cnt)
    );

    typedef struct {
        logic [10:0] frame;
        logic [7:0]  data;
        logic        pe_even;
        logic        pe_odd;
        logic        fe;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance past one rising edge; sampling and driving happen 1 unit later.
    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // One-cycle strobe, then one idle cycle: entry visible on return.
    task automatic send(input logic [10:0] f);
        data_parll    = f;
        recieved_flag = 1'b1;
        tick();
        recieved_flag = 1'b0;
        tick();
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [7:0] d, input logic fe);
        chk({name, " valid"}, {31'd0, e_valid}, 32'd1);
        chk({name, " data"}, {24'd0, e_data}, {24'd0, d});
        chk({name, " frame_err"}, {31'd0, e_fe}, {31'd0, fe});
    endtask

    initial begin
        vecs[0] = '{frame: 11'h54A, data: 8'hA5, pe_even: 1'b0, pe_odd: 1'b1, fe: 1'b0};
        vecs[1] = '{frame: 11'h74A, data: 8'hA5, pe_even: 1'b1, pe_odd: 1'b0, fe: 1'b0};
        vecs[2] = '{frame: 11'h14A, data: 8'hA5, pe_even: 1'b0, pe_odd: 1'b1, fe: 1'b1};
        vecs[3] = '{frame: 11'h678, data: 8'h3C, pe_even: 1'b1, pe_odd: 1'b0, fe: 1'b0};
        vecs[4] = '{frame: 11'h478, data: 8'h3C, pe_even: 1'b0, pe_odd: 1'b1, fe: 1'b0};
        vecs[5] = '{frame: 11'h000, data: 8'h00, pe_even: 1'b0, pe_odd: 1'b1, fe: 1'b1};
        vecs[6] = '{frame: 11'h7FF, data: 8'hFF, pe_even: 1'b1, pe_odd: 1'b0, fe: 1'b1};

        rst           = 1'b1;
        recieved_flag = 1'b0;
        data_parll    = '0;
        rx_ready      = 1'b0;
        clr_overrun   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("reset valid", {31'd0, e_valid}, 32'd0);
        chk("reset data", {24'd0, e_data}, 32'd0);
        chk("reset status", {30'd0, e_pe, e_fe}, 32'd0);
        chk("reset overrun", {31'd0, e_ovr}, 32'd0);
        chk("reset count", {29'd0, e_cnt}, 32'd0);

        // Latency: not yet valid right after the sampling edge.
        data_parll    = 11'h54A;
        recieved_flag = 1'b1;
        tick();
        recieved_flag = 1'b0;
        chk("latency early valid", {31'd0, e_valid}, 32'd0);
        tick();
        chk("latency valid", {31'd0, e_valid}, 32'd1);
        pop();

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].frame);
            chk_head($sformatf("vec%0d", i), vecs[i].data, vecs[i].fe);
            chk($sformatf("vec%0d count", i), {29'd0, e_cnt}, 32'd1);
            chk($sformatf("vec%0d pe even", i), {31'd0, e_pe}, {31'd0, vecs[i].pe_even});
            chk($sformatf("vec%0d pe odd", i), {31'd0, o_pe}, {31'd0, vecs[i].pe_odd});
            chk($sformatf("vec%0d pe none", i), {31'd0, n_pe}, 32'd0);
            pop();
            chk($sformatf("vec%0d popped valid", i), {31'd0, e_valid}, 32'd0);
            chk($sformatf("vec%0d popped out", i), {22'd0, e_data, e_pe, e_fe}, 32'd0);
        end

        // rx_ready while empty does nothing.
        pop();
        chk("empty pop count", {29'd0, e_cnt}, 32'd0);

        // Fill past capacity: the fifth frame is dropped.
        send(11'h54A);
        send(11'h678);
        send(11'h74A);
        send(11'h14A);
        chk("full no overrun yet", {31'd0, e_ovr}, 32'd0);
        send(11'h478);
        chk("overflow count", {29'd0, e_cnt}, 32'd4);
        chk("overflow overrun", {31'd0, e_ovr}, 32'd1);
        tick();
        tick();
        chk("head stable data", {24'd0, e_data}, 32'hA5);
        chk("overrun sticky", {31'd0, e_ovr}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("overrun cleared", {31'd0, e_ovr}, 32'd0);

        // Full FIFO: push and pop land on the same edge.
        data_parll    = 11'h54A;
        recieved_flag = 1'b1;
        tick();
        recieved_flag = 1'b0;
        rx_ready      = 1'b1;
        tick();
        rx_ready      = 1'b0;
        chk("push+pop count", {29'd0, e_cnt}, 32'd4);
        chk("push+pop overrun", {31'd0, e_ovr}, 32'd0);

        chk_head("drain0", 8'h3C, 1'b0);
        pop();
        chk_head("drain1", 8'hA5, 1'b0);
        chk("drain1 pe", {31'd0, e_pe}, 32'd1);
        pop();
        chk_head("drain2", 8'hA5, 1'b1);
        pop();
        chk_head("drain3", 8'hA5, 1'b0);
        chk("drain3 pe", {31'd0, e_pe}, 32'd0);
        pop();
        chk("drained count", {29'd0, e_cnt}, 32'd0);

        // Flag held high for five cycles: a single entry.
        data_parll    = 11'h678;
        recieved_flag = 1'b1;
        repeat (5) tick();
        recieved_flag = 1'b0;
        tick();
        chk("held flag count", {29'd0, e_cnt}, 32'd1);
        pop();

        // Strobes on consecutive opportunities keep order.
        send(11'h54A);
        send(11'h678);
        chk("b2b count", {29'd0, e_cnt}, 32'd2);
        chk_head("b2b first", 8'hA5, 1'b0);
        pop();
        chk_head("b2b second", 8'h3C, 1'b0);
        pop();

        // Reset during CHECK with two entries held, overrun set.
        send(11'h54A);
        send(11'h678);
        send(11'h74A);
        send(11'h14A);
        send(11'h478);
        chk("pre-reset overrun", {31'd0, e_ovr}, 32'd1);
        pop();
        pop();
        chk("pre-reset count", {29'd0, e_cnt}, 32'd2);
        data_parll    = 11'h54A;
        recieved_flag = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("mid reset count", {29'd0, e_cnt}, 32'd0);
        chk("mid reset valid", {31'd0, e_valid}, 32'd0);
        chk("mid reset overrun", {31'd0, e_ovr}, 32'd0);
        chk("mid reset data", {24'd0, e_data}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("flag across reset count", {29'd0, e_cnt}, 32'd0);
        recieved_flag = 1'b0;
        tick();
        send(11'h678);
        chk("after reset count", {29'd0, e_cnt}, 32'd1);
        chk_head("after reset", 8'h3C, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframe.md
Name: uart_rx_deframe

Overview:
- Receive-path stage directly downstream of the UART serial-to-parallel shifter.
- Consumes the 11-bit frame and its one-cycle completion flag, strips start/parity/stop, checks framing and parity, and buffers bytes with per-byte status in a small FIFO.
- Host side reads bytes through a valid/ready handshake.
- Runs on the receiver's baud_clk domain.

Parameters:
- PARITY_MODE, 0, 0 = even, 1 = odd, 2 = none (frame bit 9 ignored, parity error never set).
- FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of fifo_count; must be log2(FIFO_DEPTH)+1.

Ports:
- baud_clk  in  1  block clock (same clock as the shifter stage).
- rst  in  1  reset, synchronous, active-high.
- recieved_flag  in  1  frame-complete strobe from the shifter.
- data_parll  in  11  frame: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
- rx_data  out  8  byte at FIFO head; 0 when empty.
- rx_parity_err  out  1  parity status of the head entry.
- rx_frame_err  out  1  framing status of the head entry (start!=0 or stop!=1).
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head entry when rx_valid && rx_ready.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_overrun  in  1  clears overrun.
- fifo_count  out  CNT_W  number of entries held.

Behaviour:
- Reset (rst=1 at a baud_clk edge):
  - state=IDLE, FIFO empty, rx_valid=0, rx_data=0, both status outputs 0, overrun=0, fifo_count=0.
  - flag_q (delayed recieved_flag) is set to 1 so a flag already high at reset release is not taken as a new frame.
- Edge detect: new_frame = recieved_flag && !flag_q. frame_q <= data_parll on every new_frame, in any state.
- FSM, 2 states:
  - IDLE: on new_frame, go to CHECK.
  - CHECK: compute the status bits and attempt one FIFO write. Then go to CHECK if new_frame occurs this cycle, else to IDLE. Back-to-back frames are supported and nothing is lost.
- Status bits:
  - frame_err = frame_q[0] | ~frame_q[10].
  - parity_err: even mode = ^frame_q[9:1]; odd mode = ~^frame_q[9:1]; none mode = 0.
  - Errored frames are still stored; status travels with the byte in a 10-bit FIFO word.
- Latency: recieved_flag rises at cycle N (sampled edge N), CHECK at N+1, write at N+1, rx_valid=1 from N+2 (registered count).
- FIFO write rules:
  - Not full: write.
  - Full with a pop in the same cycle: write succeeds and count is unchanged.
  - Full with no pop: frame dropped, overrun <= 1.
- Pop: on rx_valid && rx_ready, head advances next cycle. rx_ready while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- overrun:
  - Set by a drop, cleared by clr_overrun.
  - Drop and clear in the same cycle: set wins.
  - overrun does not block further writes once space frees.
- Head outputs:
  - Combinational from the FIFO head entry, forced to 0 when empty.
  - Stable while rx_valid && !rx_ready.
- Reset mid-operation: a pending CHECK and all FIFO contents are discarded with no write. A new_frame in the reset cycle is ignored.

Decomposition:
- Package uart_rx_pkg holds:
  - frame bit index constants (START_BIT=0, DATA_LSB=1, DATA_MSB=8, PAR_BIT=9, STOP_BIT=10);
  - PARITY_EVEN/ODD/NONE encodings;
  - the FSM state enum;
  - the FIFO word layout {frame_err, parity_err, data}.
- One sub-module: uart_rx_fifo, a synchronous FIFO (width 10, depth FIFO_DEPTH) with push/pop, full/empty, count, and simultaneous push+pop when full. The deframe module holds the edge detect, FSM, checks and overrun logic.

Test Plan:
- Even mode, data_parll=0x54A, strobe 1 cycle -> rx_valid at N+2; rx_data=0xA5; parity_err=0; frame_err=0; fifo_count=1. Pulse rx_ready -> rx_valid=0, rx_data=0.
- Even mode, data_parll=0x74A -> rx_data=0xA5, parity_err=1. Then 0x14A -> frame_err=1, parity_err=0. Mode none with 0x74A -> parity_err=0.
- Odd mode, data_parll=0x678 -> rx_data=0x3C, no errors. Odd mode, 0x478 -> parity_err=1.
- rx_ready=0, FIFO_DEPTH+1 frames (0x54A repeated) -> fifo_count=4, overrun=1, first 4 bytes intact. Assert clr_overrun -> overrun=0. Full FIFO with push and pop in the same cycle -> count stays 4, overrun stays 0.
- recieved_flag held high 5 cycles -> exactly one entry written. Flag pulses on consecutive strobe edges with 0x54A then 0x678 -> both stored in order.
- rst asserted in the CHECK cycle with 2 entries held -> next cycle fifo_count=0, rx_valid=0, overrun=0. recieved_flag high during and after reset -> no entry written.
